rx_frame_commit_ctrl: RTL

RX_FRAME_COMMIT_CTRL -- requirements
Module: rx_frame_commit_ctrl

---
 rtl/rx_frame_commit_ctrl_pkg.sv | 37 +++
 rtl/rx_frame_commit_ctrl_ptr_calc.sv | 27 ++
 rtl/rx_frame_commit_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_frame_commit_ctrl_pkg
// Shared definitions for the rx frame commit controller:
//   - receive FSM state encoding
//   - default buffer address width and acceptance headroom
//   - frame counter limit and the frame counter update helper
// ---------------------------------------------------------------------------
package rx_frame_commit_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } rx_state_e;

   localparam int DEF_ADDR_W   = 9;
   localparam int DEF_HEADROOM = 32;

   localparam logic [7:0] FRAME_CNT_MAX = 8'd255;

   // Committed-frame counter update: a commit and a release in the same
   // cycle cancel out; each qualifier is expected to be legal already.
   function automatic logic [7:0] frame_cnt_step(input logic [7:0] cnt,
                                                 input logic       inc,
                                                 input logic       dec);
      logic [7:0] res;
      if (inc && !dec) begin
         res = cnt + 8'd1;
      end else if (dec && !inc) begin
         res = cnt - 8'd1;
      end else begin
         res = cnt;
      end
      return res;
   endfunction

endpackage

// File: rtl/rx_frame_commit_ctrl_ptr_calc.sv
// ---------------------------------------------------------------------------
// rx_ptr_calc
// Free-space calculation for a ring buffer addressed by wrap-bit pointers.
// Ports:
//   wr_ptr     (in,  ADDR_W+1) write pointer including wrap bit
//   rd_ptr     (in,  ADDR_W+1) read pointer including wrap bit
//   free_words (out, ADDR_W+1) DEPTH - (wr_ptr - rd_ptr)
// ---------------------------------------------------------------------------
module rx_ptr_calc #(
   parameter int ADDR_W = 9
) (
   input  logic [ADDR_W:0] wr_ptr,
   input  logic [ADDR_W:0] rd_ptr,
   output logic [ADDR_W:0] free_words
);

   localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] occupied_s;

   // Occupancy wraps naturally modulo 2^(ADDR_W+1); it never exceeds DEPTH.
   always_comb begin
      occupied_s = wr_ptr - rd_ptr;
      free_words = DEPTH_V - occupied_s;
   end

endmodule

// File: rtl/rx_frame_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_commit_ctrl
// Write/commit/read pointer control for an rx frame buffer. Words of the
// frame being received are written speculatively and only become readable
// once the frame is committed by good_frame_get; bad frames, overflowing
// frames and frames that would overflow the frame counter are rolled back.
// Ports:
//   rxclk, reset_n         clock, async active-low reset
//   get_sfd                frame start
//   data_valid             one rx word to write this cycle
//   good_frame_get         frame passed all checks (pulse)
//   bad_frame_get          frame failed a check (pulse)
//   rd_en                  reader pops one committed word
//   rd_frame_done          reader released one whole frame
//   recv_enable            rx engine may start a frame (registered)
//   wr_en, wr_addr         buffer write strobe/address (same cycle)
//   rd_addr                buffer read address
//   free_words             DEPTH minus occupied words
//   frame_cnt              committed frames not yet released
//   frame_good/bad/dropped one-cycle outcome pulses
// ---------------------------------------------------------------------------
module rx_frame_commit_ctrl
   import rx_frame_commit_ctrl_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int HEADROOM = DEF_HEADROOM
) (
   input  logic              rxclk,
   input  logic              reset_n,
   input  logic              get_sfd,
   input  logic              data_valid,
   input  logic              good_frame_get,
   input  logic              bad_frame_get,
   input  logic              rd_en,
   input  logic              rd_frame_done,
   output logic              recv_enable,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   free_words,
   output logic [7:0]        frame_cnt,
   output logic              frame_good,
   output logic              frame_bad,
   output logic              frame_dropped
);

   localparam logic [ADDR_W:0] PTR_ZERO   = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] HEADROOM_V = (ADDR_W+1)'(HEADROOM);

   rx_state_e       state_q, state_d;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]      frame_cnt_q, frame_cnt_d;
   logic            recv_enable_q, recv_enable_d;
   logic            frame_good_q, frame_good_d;
   logic            frame_bad_q, frame_bad_d;
   logic            frame_dropped_q, frame_dropped_d;

   logic [ADDR_W:0] free_cur_s;
   logic [ADDR_W:0] free_next_s;
   logic [ADDR_W:0] wr_inc_s;
   logic            wr_fire_s;
   logic            overflow_s;
   logic            release_ok_s;
   logic            rd_fire_s;
   logic            commit_s;
   logic            wr_en_s;

   // Free space seen this cycle, from the registered pointers.
   rx_ptr_calc #(.ADDR_W(ADDR_W)) u_free_cur (
      .wr_ptr     (wr_ptr_q),
      .rd_ptr     (rd_ptr_q),
      .free_words (free_cur_s)
   );

   // Free space after this clock edge, used to pre-compute recv_enable.
   rx_ptr_calc #(.ADDR_W(ADDR_W)) u_free_next (
      .wr_ptr     (wr_ptr_d),
      .rd_ptr     (rd_ptr_d),
      .free_words (free_next_s)
   );

   // Input qualifiers shared by the FSM, read pointer and frame counter.
   always_comb begin
      wr_fire_s    = data_valid & (free_cur_s != PTR_ZERO);
      overflow_s   = data_valid & (free_cur_s == PTR_ZERO);
      wr_inc_s     = {{ADDR_W{1'b0}}, wr_fire_s};
      release_ok_s = rd_frame_done & (frame_cnt_q != 8'd0);
      // Only committed words are readable.
      rd_fire_s    = rd_en & (rd_ptr_q != commit_ptr_q);
   end

   // Receive FSM: next state, write pointer, commit pointer and outcomes.
   always_comb begin
      state_d         = state_q;
      wr_ptr_d        = wr_ptr_q;
      commit_ptr_d    = commit_ptr_q;
      wr_en_s         = 1'b0;
      commit_s        = 1'b0;
      frame_good_d    = 1'b0;
      frame_bad_d     = 1'b0;
      frame_dropped_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (get_sfd && recv_enable_q) begin
               state_d = ST_RECV;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (bad_frame_get) begin
               // Bad wins over good; a word written now is discarded too.
               wr_en_s     = wr_fire_s;
               wr_ptr_d    = commit_ptr_q;
               frame_bad_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (good_frame_get) begin
               wr_en_s = wr_fire_s;
               state_d = ST_IDLE;
               // An overflowing last word or a saturated frame counter
               // (with no release this cycle) turns the commit into a drop.
               if (overflow_s || ((frame_cnt_q == FRAME_CNT_MAX) && !release_ok_s)) begin
                  wr_ptr_d        = commit_ptr_q;
                  frame_dropped_d = 1'b1;
               end else begin
                  wr_ptr_d     = wr_ptr_q + wr_inc_s;
                  commit_ptr_d = wr_ptr_q + wr_inc_s;
                  commit_s     = 1'b1;
                  frame_good_d = 1'b1;
               end
            end else if (get_sfd) begin
               // A new SFD restarts reception; the SFD cycle carries no word.
               wr_ptr_d    = commit_ptr_q;
               frame_bad_d = 1'b1;
               state_d     = ST_RECV;
            end else if (overflow_s) begin
               wr_ptr_d = commit_ptr_q;
               state_d  = ST_DROP;
            end else if (wr_fire_s) begin
               wr_en_s  = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               state_d  = ST_RECV;
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_DROP: begin
            if (good_frame_get || bad_frame_get) begin
               frame_dropped_d = 1'b1;
               state_d         = ST_IDLE;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            wr_ptr_d = commit_ptr_q;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // Read pointer, frame counter and registered receive permission.
   always_comb begin
      if (rd_fire_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      frame_cnt_d   = frame_cnt_step(frame_cnt_q, commit_s, release_ok_s);
      recv_enable_d = (state_d == ST_IDLE) && (free_next_s >= HEADROOM_V);
   end

   // State, pointer, counter and pulse registers.
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         wr_ptr_q        <= PTR_ZERO;
         commit_ptr_q    <= PTR_ZERO;
         rd_ptr_q        <= PTR_ZERO;
         frame_cnt_q     <= 8'd0;
         recv_enable_q   <= 1'b0;
         frame_good_q    <= 1'b0;
         frame_bad_q     <= 1'b0;
         frame_dropped_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         wr_ptr_q        <= wr_ptr_d;
         commit_ptr_q    <= commit_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         frame_cnt_q     <= frame_cnt_d;
         recv_enable_q   <= recv_enable_d;
         frame_good_q    <= frame_good_d;
         frame_bad_q     <= frame_bad_d;
         frame_dropped_q <= frame_dropped_d;
      end
   end

   assign recv_enable   = recv_enable_q;
   assign wr_en         = wr_en_s;
   assign wr_addr       = wr_ptr_q[ADDR_W-1:0];
   assign rd_addr       = rd_ptr_q[ADDR_W-1:0];
   assign free_words    = free_cur_s;
   assign frame_cnt     = frame_cnt_q;
   assign frame_good    = frame_good_q;
   assign frame_bad     = frame_bad_q;
   assign frame_dropped = frame_dropped_q;

endmodule
